// File: rtl/vcap_frame_seq.sv
// -----------------------------------------------------------------------------
// vcap_frame_seq
// Frame-capture sequencer for the vcap stream capture path (pixel clock domain).
// Arms on command, aligns the start of capture to a frame boundary, gates the
// pixel FIFO write, counts captured lines and raises one line-write request per
// line towards the memory writer. Alternates between two frame buffers and
// supports single-shot and continuous capture.
//
// Ports
//   i_clk            pixel clock
//   i_reset_n        asynchronous active-low reset
//   i_cmd_arm        pulse: start capture (also clears sticky flags)
//   i_cmd_cont       level: 1 = continuous, sampled at frame end
//   i_cmd_stop       pulse: abort capture
//   i_vs_negedge     pulse: frame start
//   i_active_negedge pulse: end of active line
//   i_y_size         last line index (frame = i_y_size+1 lines)
//   i_wr_ack         memory writer accepts the pending request
//   o_cap_en         pixel FIFO write enable
//   o_wr_req         line-write request, held until acknowledged
//   o_wr_addr        {buf, line, STRIDE_LOG2 zero bits}
//   o_frame_done     pulse: a complete frame has been written
//   o_buf_sel        buffer currently being filled
//   o_busy           sequencer not idle
//   o_overrun        sticky: line end while a request was still pending
//   o_short_frame    sticky: frame start before all lines were captured
// -----------------------------------------------------------------------------
module vcap_frame_seq #(
    parameter  int LINE_BITS   = 9,
    parameter  int STRIDE_LOG2 = 10,
    localparam int AW          = 1 + LINE_BITS + STRIDE_LOG2
) (
    input  logic                 i_clk,
    input  logic                 i_reset_n,
    input  logic                 i_cmd_arm,
    input  logic                 i_cmd_cont,
    input  logic                 i_cmd_stop,
    input  logic                 i_vs_negedge,
    input  logic                 i_active_negedge,
    input  logic [LINE_BITS-1:0] i_y_size,
    input  logic                 i_wr_ack,
    output logic                 o_cap_en,
    output logic                 o_wr_req,
    output logic [AW-1:0]        o_wr_addr,
    output logic                 o_frame_done,
    output logic                 o_buf_sel,
    output logic                 o_busy,
    output logic                 o_overrun,
    output logic                 o_short_frame
);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_WAIT_VS = 2'd1,
        ST_CAPTURE = 2'd2,
        ST_FLUSH   = 2'd3
    } state_e;

    state_e                 state_q, state_d;
    logic [LINE_BITS-1:0]   line_cnt_q, line_cnt_d;
    logic                   cap_en_q, cap_en_d;
    logic                   wr_req_q, wr_req_d;
    logic [AW-1:0]          wr_addr_q, wr_addr_d;
    logic                   frame_done_q, frame_done_d;
    logic                   buf_sel_q, buf_sel_d;
    logic                   busy_q, busy_d;
    logic                   overrun_q, overrun_d;
    logic                   short_frame_q, short_frame_d;
    logic                   abort_q, abort_d;

    logic                   last_line_s;
    logic [AW-1:0]          line_addr_s;

    // >= rather than == so a y_size lowered mid-frame still terminates the frame
    assign last_line_s = (line_cnt_q >= i_y_size);
    assign line_addr_s = {buf_sel_q, line_cnt_q, {STRIDE_LOG2{1'b0}}};

    // State register
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state decode
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (i_cmd_arm) begin
                    state_d = ST_WAIT_VS;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_WAIT_VS: begin
                if (i_cmd_stop) begin
                    state_d = ST_IDLE;
                end else if (i_vs_negedge) begin
                    state_d = ST_CAPTURE;
                end else begin
                    state_d = ST_WAIT_VS;
                end
            end
            ST_CAPTURE: begin
                if (i_cmd_stop) begin
                    state_d = ST_FLUSH;
                end else if (i_vs_negedge) begin
                    state_d = ST_CAPTURE;
                end else if (i_active_negedge && last_line_s) begin
                    state_d = ST_FLUSH;
                end else begin
                    state_d = ST_CAPTURE;
                end
            end
            ST_FLUSH: begin
                if (wr_req_q) begin
                    state_d = ST_FLUSH;
                end else if (abort_q) begin
                    state_d = ST_IDLE;
                end else if (i_cmd_cont) begin
                    state_d = ST_WAIT_VS;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Output / datapath next values
    always_comb begin
        line_cnt_d    = line_cnt_q;
        cap_en_d      = cap_en_q;
        wr_addr_d     = wr_addr_q;
        frame_done_d  = 1'b0;
        buf_sel_d     = buf_sel_q;
        abort_d       = abort_q;
        busy_d        = (state_d != ST_IDLE);

        // An acknowledge retires the pending request; ack without request is ignored
        if (wr_req_q && i_wr_ack) begin
            wr_req_d = 1'b0;
        end else begin
            wr_req_d = wr_req_q;
        end

        // Arm clears the sticky flags; a same-cycle set below still wins
        if (i_cmd_arm) begin
            overrun_d     = 1'b0;
            short_frame_d = 1'b0;
        end else begin
            overrun_d     = overrun_q;
            short_frame_d = short_frame_q;
        end

        case (state_q)
            ST_IDLE: begin
                cap_en_d = 1'b0;
                if (i_cmd_arm) begin
                    abort_d = 1'b0;
                end else begin
                    abort_d = abort_q;
                end
            end
            ST_WAIT_VS: begin
                if (!i_cmd_stop && i_vs_negedge) begin
                    cap_en_d   = 1'b1;
                    line_cnt_d = {LINE_BITS{1'b0}};
                end else begin
                    cap_en_d   = 1'b0;
                end
            end
            ST_CAPTURE: begin
                if (i_cmd_stop) begin
                    // Stop wins over a same-cycle line end: that line is dropped
                    cap_en_d = 1'b0;
                    abort_d  = 1'b1;
                end else if (i_vs_negedge) begin
                    short_frame_d = 1'b1;
                    line_cnt_d    = {LINE_BITS{1'b0}};
                end else if (i_active_negedge) begin
                    if (!wr_req_q || i_wr_ack) begin
                        wr_req_d  = 1'b1;
                        wr_addr_d = line_addr_s;
                    end else begin
                        overrun_d = 1'b1;
                    end
                    if (last_line_s) begin
                        cap_en_d   = 1'b0;
                        line_cnt_d = line_cnt_q;
                    end else begin
                        line_cnt_d = line_cnt_q + LINE_BITS'(1);
                    end
                end else begin
                    cap_en_d = 1'b1;
                end
            end
            ST_FLUSH: begin
                cap_en_d = 1'b0;
                if (!wr_req_q) begin
                    if (!abort_q) begin
                        frame_done_d = 1'b1;
                        buf_sel_d    = ~buf_sel_q;
                    end else begin
                        frame_done_d = 1'b0;
                    end
                    abort_d = 1'b0;
                end else begin
                    abort_d = abort_q;
                end
            end
            default: begin
                cap_en_d = 1'b0;
            end
        endcase
    end

    // Output and datapath registers
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            line_cnt_q    <= {LINE_BITS{1'b0}};
            cap_en_q      <= 1'b0;
            wr_req_q      <= 1'b0;
            wr_addr_q     <= {AW{1'b0}};
            frame_done_q  <= 1'b0;
            buf_sel_q     <= 1'b0;
            busy_q        <= 1'b0;
            overrun_q     <= 1'b0;
            short_frame_q <= 1'b0;
            abort_q       <= 1'b0;
        end else begin
            line_cnt_q    <= line_cnt_d;
            cap_en_q      <= cap_en_d;
            wr_req_q      <= wr_req_d;
            wr_addr_q     <= wr_addr_d;
            frame_done_q  <= frame_done_d;
            buf_sel_q     <= buf_sel_d;
            busy_q        <= busy_d;
            overrun_q     <= overrun_d;
            short_frame_q <= short_frame_d;
            abort_q       <= abort_d;
        end
    end

    assign o_cap_en      = cap_en_q;
    assign o_wr_req      = wr_req_q;
    assign o_wr_addr     = wr_addr_q;
    assign o_frame_done  = frame_done_q;
    assign o_buf_sel     = buf_sel_q;
    assign o_busy        = busy_q;
    assign o_overrun     = overrun_q;
    assign o_short_frame = short_frame_q;

endmodule

// File: tb/tb_vcap_frame_seq.sv
// -----------------------------------------------------------------------------
// Directed self-checking bench for vcap_frame_seq.
// -----------------------------------------------------------------------------
module tb_vcap_frame_seq;

    localparam int LINE_BITS   = 9;
    localparam int STRIDE_LOG2 = 10;
    localparam int AW          = 1 + LINE_BITS + STRIDE_LOG2;

    logic                 clk;
    logic                 rst_n;
    logic                 cmd_arm;
    logic                 cmd_cont;
    logic                 cmd_stop;
    logic                 vs_negedge;
    logic                 active_negedge;
    logic [LINE_BITS-1:0] y_size;
    logic                 wr_ack;
    logic                 cap_en;
    logic                 wr_req;
    logic [AW-1:0]        wr_addr;
    logic                 frame_done;
    logic                 buf_sel;
    logic                 busy;
    logic                 overrun;
    logic                 short_frame;

    int n_tests;
    int n_fail;

    vcap_frame_seq #(
        .LINE_BITS   (LINE_BITS),
        .STRIDE_LOG2 (STRIDE_LOG2)
    ) dut (
        .i_clk            (clk),
        .i_reset_n        (rst_n),
        .i_cmd_arm        (cmd_arm),
        .i_cmd_cont       (cmd_cont),
        .i_cmd_stop       (cmd_stop),
        .i_vs_negedge     (vs_negedge),
        .i_active_negedge (active_negedge),
        .i_y_size         (y_size),
        .i_wr_ack         (wr_ack),
        .o_cap_en         (cap_en),
        .o_wr_req         (wr_req),
        .o_wr_addr        (wr_addr),
        .o_frame_done     (frame_done),
        .o_buf_sel        (buf_sel),
        .o_busy           (busy),
        .o_overrun        (overrun),
        .o_short_frame    (short_frame)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic arm();
        cmd_arm = 1'b1;
        tick();
        cmd_arm = 1'b0;
    endtask

    task automatic frame_start();
        vs_negedge = 1'b1;
        tick();
        vs_negedge = 1'b0;
    endtask

    // Line end strobe, then check request/address, then acknowledge it
    task automatic line_acked(input string tag, input logic [31:0] exp_addr);
        active_negedge = 1'b1;
        tick();
        active_negedge = 1'b0;
        check({tag, "_req"}, 32'(wr_req), 32'd1);
        check({tag, "_addr"}, 32'(wr_addr), exp_addr);
        wr_ack = 1'b1;
        tick();
        wr_ack = 1'b0;
        check({tag, "_req_clr"}, 32'(wr_req), 32'd0);
    endtask

    initial begin
        n_tests        = 0;
        n_fail         = 0;
        rst_n          = 1'b0;
        cmd_arm        = 1'b0;
        cmd_cont       = 1'b0;
        cmd_stop       = 1'b0;
        vs_negedge     = 1'b0;
        active_negedge = 1'b0;
        y_size         = 9'd3;
        wr_ack         = 1'b0;

        // ---------------- reset ----------------
        tick(); tick();
        rst_n = 1'b1;
        tick();
        check("rst_outputs", {24'd0, cap_en, wr_req, frame_done, buf_sel, busy, overrun, short_frame, 1'b0}, 32'd0);
        check("rst_addr", 32'(wr_addr), 32'd0);

        // ack with nothing pending is ignored
        wr_ack = 1'b1;
        tick();
        wr_ack = 1'b0;
        check("idle_ack_req", 32'(wr_req), 32'd0);

        // ---------------- single frame, 4 lines ----------------
        arm();
        check("sf_busy", 32'(busy), 32'd1);
        check("sf_cap_wait", 32'(cap_en), 32'd0);
        frame_start();
        check("sf_cap_en", 32'(cap_en), 32'd1);
        line_acked("sf_l0", 32'h00000);
        line_acked("sf_l1", 32'h00400);
        line_acked("sf_l2", 32'h00800);
        active_negedge = 1'b1;
        tick();
        active_negedge = 1'b0;
        check("sf_l3_addr", 32'(wr_addr), 32'h00C00);
        check("sf_l3_cap_off", 32'(cap_en), 32'd0);
        wr_ack = 1'b1;
        tick();
        wr_ack = 1'b0;
        check("sf_done_wait", 32'(frame_done), 32'd0);
        tick();
        check("sf_done", 32'(frame_done), 32'd1);
        check("sf_buf", 32'(buf_sel), 32'd1);
        check("sf_idle", 32'(busy), 32'd0);
        tick();
        check("sf_done_pulse", 32'(frame_done), 32'd0);

        // ---------------- continuous, 2 frames of 2 lines ----------------
        y_size   = 9'd1;
        cmd_cont = 1'b1;
        arm();
        frame_start();
        line_acked("ct_a0", 32'h80000);
        line_acked("ct_a1", 32'h80400);
        tick();
        check("ct_a_done", 32'(frame_done), 32'd1);
        check("ct_a_buf", 32'(buf_sel), 32'd0);
        check("ct_a_busy", 32'(busy), 32'd1);
        frame_start();
        check("ct_b_cap", 32'(cap_en), 32'd1);
        line_acked("ct_b0", 32'h00000);
        line_acked("ct_b1", 32'h00400);
        cmd_cont = 1'b0;
        tick();
        check("ct_b_done", 32'(frame_done), 32'd1);
        check("ct_b_buf", 32'(buf_sel), 32'd1);
        check("ct_b_idle", 32'(busy), 32'd0);

        // ---------------- overrun ----------------
        y_size = 9'd3;
        arm();
        frame_start();
        active_negedge = 1'b1;
        tick();
        check("ov_l0_addr", 32'(wr_addr), 32'h80000);
        tick();
        active_negedge = 1'b0;
        check("ov_flag", 32'(overrun), 32'd1);
        check("ov_req_held", 32'(wr_req), 32'd1);
        check("ov_addr_held", 32'(wr_addr), 32'h80000);
        wr_ack = 1'b1;
        tick();
        wr_ack = 1'b0;
        line_acked("ov_l2", 32'h80800);
        line_acked("ov_l3", 32'h80C00);
        tick();
        check("ov_done", 32'(frame_done), 32'd1);
        check("ov_sticky", 32'(overrun), 32'd1);
        check("ov_buf", 32'(buf_sel), 32'd0);

        // ---------------- stop mid-frame ----------------
        arm();
        check("st_arm_clr", 32'(overrun), 32'd0);
        frame_start();
        line_acked("st_l0", 32'h00000);
        active_negedge = 1'b1;
        tick();
        active_negedge = 1'b0;
        check("st_l1_addr", 32'(wr_addr), 32'h00400);
        cmd_stop = 1'b1;
        tick();
        cmd_stop = 1'b0;
        check("st_cap_off", 32'(cap_en), 32'd0);
        check("st_req_held", 32'(wr_req), 32'd1);
        tick();
        check("st_wait_busy", 32'(busy), 32'd1);
        wr_ack = 1'b1;
        tick();
        wr_ack = 1'b0;
        check("st_req_clr", 32'(wr_req), 32'd0);
        tick();
        check("st_no_done", 32'(frame_done), 32'd0);
        check("st_idle", 32'(busy), 32'd0);
        check("st_buf", 32'(buf_sel), 32'd0);

        // ---------------- short frame ----------------
        arm();
        frame_start();
        line_acked("sh_l0", 32'h00000);
        line_acked("sh_l1", 32'h00400);
        frame_start();
        check("sh_flag", 32'(short_frame), 32'd1);
        check("sh_cap", 32'(cap_en), 32'd1);
        line_acked("sh_r0", 32'h00000);
        line_acked("sh_r1", 32'h00400);
        line_acked("sh_r2", 32'h00800);
        line_acked("sh_r3", 32'h00C00);
        tick();
        check("sh_done", 32'(frame_done), 32'd1);
        check("sh_buf", 32'(buf_sel), 32'd1);
        check("sh_sticky", 32'(short_frame), 32'd1);

        // ---------------- async reset mid-frame ----------------
        arm();
        frame_start();
        active_negedge = 1'b1;
        tick();
        active_negedge = 1'b0;
        check("ar_req_pre", 32'(wr_req), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check("ar_req", 32'(wr_req), 32'd0);
        check("ar_busy", 32'(busy), 32'd0);
        check("ar_cap", 32'(cap_en), 32'd0);
        check("ar_addr", 32'(wr_addr), 32'd0);
        check("ar_flags", {29'd0, buf_sel, short_frame, overrun}, 32'd0);
        tick();
        rst_n = 1'b1;
        tick();
        check("ar_idle", 32'(busy), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
